alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the main execute stage and a branch/compare helper.
- Each request carries a full ALU operand set (OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL).
- Round-robin arbitration; the winner's operands are registered, the ALU is held stable for EXEC_CYCLES, and RESULT/SIG_B are captured into a response buffer with a valid/ready handshake.

Parameters:
- EXEC_CYCLES, 1, cycles the operand register holds the ALU before the result is captured; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQn_VALID  in  1  request from requester n (n=0,1).
- REQn_READY  out  1  request n accepted this cycle.
- REQn_OPCODE  in  6  operand; the same pattern applies to REQn_RS_VAL (32), REQn_RT_VAL (32), REQn_SHAMT (5), REQn_FUNC (6), REQn_RAW_VAL (16).
- ALU_OPCODE  out  6  registered operand to the ALU; the same pattern applies to ALU_RS_VAL (32), ALU_RT_VAL (32), ALU_SHAMT (5), ALU_FUNC (6), ALU_RAW_VAL (16).
- ALU_RESULT  in  32  ALU RESULT.
- ALU_SIG_B  in  1  ALU SIG_B.
- RSP_VALID  out  1  response buffer full.
- RSP_READY  in  1  consumer accepts the response.
- RSP_ID  out  1  requester index that owns the response.
- RSP_RESULT  out  32  captured result.
- RSP_SIG_B  out  1  captured SIG_B.

Behaviour:
- Reset state:
  - All registered outputs (ALU_*, RSP_*) are 0.
  - State = IDLE, LAST_GNT = 1, so requester 0 wins the first tie.
  - REQn_READY = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection: if only one VALID is high, that requester wins. If both are high, the one != LAST_GNT wins.
  - REQn_READY is combinational; it is high only for the winner, only in IDLE.
  - On the edge where VALID&&READY: latch the winner's operands into ALU_*, RSP_ID <= winner, LAST_GNT <= winner, CNT <= EXEC_CYCLES-1, go to EXEC.
  - No VALID: stay in IDLE.
- EXEC:
  - ALU_* stay stable.
  - Each edge with CNT != 0: CNT decrements.
  - Edge with CNT == 0: RSP_RESULT <= ALU_RESULT, RSP_SIG_B <= ALU_SIG_B, RSP_VALID <= 1, go to RESP.
- RESP:
  - RSP_* are held stable until RSP_READY is sampled high.
  - On that edge: RSP_VALID <= 0, go to IDLE.
  - No READY is issued in EXEC or RESP, so requests are never accepted mid-transaction.
- Latency: acceptance edge T0 -> RSP_VALID high after edge T0+EXEC_CYCLES. Throughput is at most one op per EXEC_CYCLES+2 cycles when RSP_READY is held high.
- ALU_* keep the last transaction's operands after completion; they are not cleared.
- Requester contract: hold VALID and payload stable until READY. The arbiter does not detect violations.
- A requester dropping VALID in IDLE before a grant is legal; no grant is issued to it.
- CNT is a 4-bit counter. No arithmetic on data; operands and results pass through unmodified.
- Asynchronous RST in any state aborts the transaction immediately:
  - no response is emitted;
  - RSP_VALID = 0;
  - the requester must re-present its request.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs GNT0_CNT and GNT1_CNT (16 bits each, registered, reset 0).
  - Each increments on its requester's acceptance edge and wraps 0xFFFF -> 0x0000.
  - Both counters are unaffected by RSP backpressure.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- RST pulse mid-simulation -> all ALU_*, RSP_* = 0, RSP_VALID = 0, both READY low while no VALID.
- REQ0 alone, OPCODE=6'b001110, RS_VAL=20, RAW_VAL=19, EXEC_CYCLES=1, real ALU attached, RSP_READY=1 -> REQ0_READY high one cycle; one edge later RSP_VALID=1, RSP_ID=0, RSP_RESULT=7.
- REQ0 (XORI, RS=33, RAW=14) and REQ1 (XORI, RS=10, RAW=8) both VALID from reset -> first response ID=0, RESULT=47; second ID=1, RESULT=2. Re-assert both -> grant order continues 0, 1 alternating.
- RSP_READY held low 5 cycles after RSP_VALID -> RSP_RESULT/RSP_ID stable, both REQn_READY stay 0 despite VALID. RSP_READY=1 -> next grant in the following IDLE cycle.
- EXEC_CYCLES=3 -> RSP_VALID rises exactly 3 edges after acceptance; ALU_* constant throughout EXEC.
- RST asserted during EXEC -> RSP_VALID never rises for that op; after release the same request is re-granted and completes with the correct result.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters with round-robin
//   arbitration. The winner's operand set is registered onto ALU_*. Those
//   registers hold the ALU inputs steady for EXEC_CYCLES cycles. Then
//   ALU_RESULT/ALU_SIG_B are captured into a one-entry response buffer,
//   which is drained with a valid/ready handshake.
//
//   Parameters:
//     EXEC_CYCLES  cycles the ALU is held before capture (1..15)
//
//   Ports:
//     CLK, RST                 clock (rising edge), async active-high reset
//     REQn_VALID / REQn_READY  request handshake, n = 0,1
//     REQn_OPCODE..RAW_VAL     request operand set
//     ALU_OPCODE..RAW_VAL      registered operands driven to the ALU
//     ALU_RESULT, ALU_SIG_B    ALU outputs
//     RSP_VALID / RSP_READY    response handshake
//     RSP_ID                   requester that owns the response
//     RSP_RESULT, RSP_SIG_B    captured ALU outputs
//
//   Optional feature (macro ALU_ARB_STATS_EN):
//     GNT0_CNT, GNT1_CNT       16-bit wrapping acceptance counters

module alu_share_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [5:0]  REQ0_OPCODE,
  input  logic [31:0] REQ0_RS_VAL,
  input  logic [31:0] REQ0_RT_VAL,
  input  logic [4:0]  REQ0_SHAMT,
  input  logic [5:0]  REQ0_FUNC,
  input  logic [15:0] REQ0_RAW_VAL,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [5:0]  REQ1_OPCODE,
  input  logic [31:0] REQ1_RS_VAL,
  input  logic [31:0] REQ1_RT_VAL,
  input  logic [4:0]  REQ1_SHAMT,
  input  logic [5:0]  REQ1_FUNC,
  input  logic [15:0] REQ1_RAW_VAL,
  output logic [5:0]  ALU_OPCODE,
  output logic [31:0] ALU_RS_VAL,
  output logic [31:0] ALU_RT_VAL,
  output logic [4:0]  ALU_SHAMT,
  output logic [5:0]  ALU_FUNC,
  output logic [15:0] ALU_RAW_VAL,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_SIG_B,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ID,
  output logic [31:0] RSP_RESULT,
  output logic        RSP_SIG_B
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] GNT0_CNT,
  output logic [15:0] GNT1_CNT
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      state_q;
  logic        last_gnt_q;
  logic [3:0]  cnt_q;
  logic [5:0]  alu_opcode_q;
  logic [31:0] alu_rs_val_q;
  logic [31:0] alu_rt_val_q;
  logic [4:0]  alu_shamt_q;
  logic [5:0]  alu_func_q;
  logic [15:0] alu_raw_val_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic        rsp_sig_b_q;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt0_cnt_q;
  logic [15:0] gnt1_cnt_q;
`endif

  logic gnt_d;
  logic accept;

  // On a tie the requester that did not win last time is granted;
  // otherwise whichever one is valid.
  always_comb begin
    gnt_d = REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) gnt_d = ~last_gnt_q;
  end

  assign REQ0_READY = (state_q == ST_IDLE) && REQ0_VALID && !gnt_d;
  assign REQ1_READY = (state_q == ST_IDLE) && REQ1_VALID &&  gnt_d;
  assign accept     = REQ0_READY || REQ1_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      last_gnt_q    <= 1'b1;
      cnt_q         <= '0;
      alu_opcode_q  <= '0;
      alu_rs_val_q  <= '0;
      alu_rt_val_q  <= '0;
      alu_shamt_q   <= '0;
      alu_func_q    <= '0;
      alu_raw_val_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_sig_b_q   <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      gnt0_cnt_q    <= '0;
      gnt1_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (gnt_d) begin
              alu_opcode_q  <= REQ1_OPCODE;
              alu_rs_val_q  <= REQ1_RS_VAL;
              alu_rt_val_q  <= REQ1_RT_VAL;
              alu_shamt_q   <= REQ1_SHAMT;
              alu_func_q    <= REQ1_FUNC;
              alu_raw_val_q <= REQ1_RAW_VAL;
            end else begin
              alu_opcode_q  <= REQ0_OPCODE;
              alu_rs_val_q  <= REQ0_RS_VAL;
              alu_rt_val_q  <= REQ0_RT_VAL;
              alu_shamt_q   <= REQ0_SHAMT;
              alu_func_q    <= REQ0_FUNC;
              alu_raw_val_q <= REQ0_RAW_VAL;
            end
            rsp_id_q   <= gnt_d;
            last_gnt_q <= gnt_d;
            cnt_q      <= CNT_INIT;
            state_q    <= ST_EXEC;
`ifdef ALU_ARB_STATS_EN
            if (gnt_d) gnt1_cnt_q <= gnt1_cnt_q + 16'd1;
            else       gnt0_cnt_q <= gnt0_cnt_q + 16'd1;
`endif
          end
        end
        ST_EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_result_q <= ALU_RESULT;
            rsp_sig_b_q  <= ALU_SIG_B;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ALU_OPCODE  = alu_opcode_q;
  assign ALU_RS_VAL  = alu_rs_val_q;
  assign ALU_RT_VAL  = alu_rt_val_q;
  assign ALU_SHAMT   = alu_shamt_q;
  assign ALU_FUNC    = alu_func_q;
  assign ALU_RAW_VAL = alu_raw_val_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_ID      = rsp_id_q;
  assign RSP_RESULT  = rsp_result_q;
  assign RSP_SIG_B   = rsp_sig_b_q;
`ifdef ALU_ARB_STATS_EN
  assign GNT0_CNT    = gnt0_cnt_q;
  assign GNT1_CNT    = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Two arbiter instances (EXEC_CYCLES = 1 and 3), each with a small
//   behavioural ALU attached. Requests are generated randomly and tracked in
//   a per-instance model: a pending set, round-robin last-winner, and an
//   expected result computed from the granted operands.

module tb_alu_share_arbiter;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] raw;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld   [2][2];
  req_t        req   [2][2];
  logic        rdy   [2][2];
  logic [5:0]  alu_op  [2];
  logic [31:0] alu_rs  [2];
  logic [31:0] alu_rt  [2];
  logic [4:0]  alu_sh  [2];
  logic [5:0]  alu_fn  [2];
  logic [15:0] alu_raw [2];
  logic [31:0] alu_res [2];
  logic        alu_sgb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_id    [2];
  logic [31:0] rsp_res   [2];
  logic        rsp_sgb   [2];

  int unsigned errors = 0;
  int unsigned checks = 0;

  // model state
  logic pend [2][2];
  req_t preq [2][2];
  int   last [2];

  always #5 clk = ~clk;

  // Behavioural ALU: {SIG_B, RESULT}; SIG_B is the rs==rt compare.
  function automatic logic [32:0] alu_f(input req_t r);
    logic [31:0] res;
    case (r.op)
      6'b001110: res = r.rs ^ {16'h0, r.raw};
      6'b001001: res = r.rs + {{16{r.raw[15]}}, r.raw};
      6'b001100: res = r.rs & {16'h0, r.raw};
      6'b001101: res = r.rs | {16'h0, r.raw};
      6'b000000: begin
        case (r.fn)
          6'h21:   res = r.rs + r.rt;
          6'h23:   res = r.rs - r.rt;
          6'h00:   res = r.rt << r.sh;
          6'h2A:   res = ($signed(r.rs) < $signed(r.rt)) ? 32'd1 : 32'd0;
          default: res = r.rs;
        endcase
      end
      default: res = r.rs;
    endcase
    return {(r.rs == r.rt), res};
  endfunction

  always_comb {alu_sgb[0], alu_res[0]} = alu_f({alu_op[0], alu_rs[0], alu_rt[0], alu_sh[0], alu_fn[0], alu_raw[0]});
  always_comb {alu_sgb[1], alu_res[1]} = alu_f({alu_op[1], alu_rs[1], alu_rt[1], alu_sh[1], alu_fn[1], alu_raw[1]});

  alu_share_arbiter #(.EXEC_CYCLES(1)) u_dut1 (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(vld[0][0]), .REQ0_READY(rdy[0][0]),
    .REQ0_OPCODE(req[0][0].op), .REQ0_RS_VAL(req[0][0].rs), .REQ0_RT_VAL(req[0][0].rt),
    .REQ0_SHAMT(req[0][0].sh), .REQ0_FUNC(req[0][0].fn), .REQ0_RAW_VAL(req[0][0].raw),
    .REQ1_VALID(vld[0][1]), .REQ1_READY(rdy[0][1]),
    .REQ1_OPCODE(req[0][1].op), .REQ1_RS_VAL(req[0][1].rs), .REQ1_RT_VAL(req[0][1].rt),
    .REQ1_SHAMT(req[0][1].sh), .REQ1_FUNC(req[0][1].fn), .REQ1_RAW_VAL(req[0][1].raw),
    .ALU_OPCODE(alu_op[0]), .ALU_RS_VAL(alu_rs[0]), .ALU_RT_VAL(alu_rt[0]),
    .ALU_SHAMT(alu_sh[0]), .ALU_FUNC(alu_fn[0]), .ALU_RAW_VAL(alu_raw[0]),
    .ALU_RESULT(alu_res[0]), .ALU_SIG_B(alu_sgb[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_ID(rsp_id[0]),
    .RSP_RESULT(rsp_res[0]), .RSP_SIG_B(rsp_sgb[0])
  );

  alu_share_arbiter #(.EXEC_CYCLES(3)) u_dut3 (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(vld[1][0]), .REQ0_READY(rdy[1][0]),
    .REQ0_OPCODE(req[1][0].op), .REQ0_RS_VAL(req[1][0].rs), .REQ0_RT_VAL(req[1][0].rt),
    .REQ0_SHAMT(req[1][0].sh), .REQ0_FUNC(req[1][0].fn), .REQ0_RAW_VAL(req[1][0].raw),
    .REQ1_VALID(vld[1][1]), .REQ1_READY(rdy[1][1]),
    .REQ1_OPCODE(req[1][1].op), .REQ1_RS_VAL(req[1][1].rs), .REQ1_RT_VAL(req[1][1].rt),
    .REQ1_SHAMT(req[1][1].sh), .REQ1_FUNC(req[1][1].fn), .REQ1_RAW_VAL(req[1][1].raw),
    .ALU_OPCODE(alu_op[1]), .ALU_RS_VAL(alu_rs[1]), .ALU_RT_VAL(alu_rt[1]),
    .ALU_SHAMT(alu_sh[1]), .ALU_FUNC(alu_fn[1]), .ALU_RAW_VAL(alu_raw[1]),
    .ALU_RESULT(alu_res[1]), .ALU_SIG_B(alu_sgb[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_ID(rsp_id[1]),
    .RSP_RESULT(rsp_res[1]), .RSP_SIG_B(rsp_sgb[1])
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t alu_now(input int k);
    return {alu_op[k], alu_rs[k], alu_rt[k], alu_sh[k], alu_fn[k], alu_raw[k]};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [5:0] fns [4] = '{6'h21, 6'h23, 6'h00, 6'h2A};
    logic [5:0] ops [4] = '{6'b001110, 6'b001001, 6'b001100, 6'b001101};
    r.rs  = $urandom;
    r.rt  = ($urandom_range(0, 3) == 0) ? r.rs : $urandom;
    r.sh  = 5'($urandom);
    r.raw = 16'($urandom);
    r.fn  = fns[$urandom_range(0, 3)];
    r.op  = ($urandom_range(0, 2) == 0) ? 6'b000000 : ops[$urandom_range(0, 3)];
    return r;
  endfunction

  function automatic req_t mk(input logic [5:0] op, input logic [31:0] rs, input logic [15:0] raw);
    req_t r;
    r = '0;
    r.op = op; r.rs = rs; r.raw = raw;
    return r;
  endfunction

  task automatic present(input int k, input int r, input req_t p);
    pend[k][r] = 1'b1;
    preq[k][r] = p;
    req[k][r]  = p;
    vld[k][r]  = 1'b1;
  endtask

  task automatic check_cleared(input int k);
    check_eq("rst_alu",    128'(alu_now(k)), '0);
    check_eq("rst_rspv",   128'(rsp_valid[k]), 0);
    check_eq("rst_rspid",  128'(rsp_id[k]), 0);
    check_eq("rst_rspres", 128'(rsp_res[k]), 0);
    check_eq("rst_rspsgb", 128'(rsp_sgb[k]), 0);
    check_eq("rst_rdy0",   128'(rdy[k][0]), 0);
    check_eq("rst_rdy1",   128'(rdy[k][1]), 0);
  endtask

  // Called just after a negedge with the DUT in IDLE and requests driven.
  // Ends at the negedge where the response has just been consumed.
  task automatic do_txn(input int k, input int h);
    int ec;
    int w;
    req_t p;
    logic [32:0] e;
    ec = (k == 0) ? 1 : 3;
    w = (pend[k][0] && pend[k][1]) ? (1 - last[k]) : (pend[k][0] ? 0 : 1);
    check_eq("grant0", 128'(rdy[k][0]), 128'(w == 0));
    check_eq("grant1", 128'(rdy[k][1]), 128'(w == 1));
    p = preq[k][w];
    e = alu_f(p);
    last[k] = w;
    pend[k][w] = 1'b0;
    @(negedge clk);
    vld[k][w] = 1'b0;
    check_eq("alu_load", 128'(alu_now(k)), 128'(p));
    for (int i = 1; i <= ec; i++) begin
      check_eq("exec_rspv", 128'(rsp_valid[k]), 0);
      check_eq("exec_rdy", 128'({rdy[k][0], rdy[k][1]}), 0);
      @(negedge clk);
      check_eq("alu_hold", 128'(alu_now(k)), 128'(p));
    end
    check_eq("rsp_valid", 128'(rsp_valid[k]), 1);
    check_eq("rsp_id",    128'(rsp_id[k]), 128'(w));
    check_eq("rsp_res",   128'(rsp_res[k]), 128'(e[31:0]));
    check_eq("rsp_sgb",   128'(rsp_sgb[k]), 128'(e[32]));
    for (int j = 0; j < h; j++) begin
      @(negedge clk);
      check_eq("bp_valid", 128'(rsp_valid[k]), 1);
      check_eq("bp_res",   128'({rsp_id[k], rsp_sgb[k], rsp_res[k]}), 128'({w[0], e[32], e[31:0]}));
      check_eq("bp_rdy",   128'({rdy[k][0], rdy[k][1]}), 0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check_eq("rsp_done", 128'(rsp_valid[k]), 0);
  endtask

  task automatic random_txn(input int k);
    for (int r = 0; r < 2; r++)
      if (!pend[k][r] && $urandom_range(0, 1) == 1) present(k, r, rand_req());
    if (!pend[k][0] && !pend[k][1]) present(k, $urandom_range(0, 1), rand_req());
    #1;
    do_txn(k, $urandom_range(0, 3));
  endtask

  task automatic drain(input int k);
    for (int n = 0; n < 2; n++)
      if (pend[k][0] || pend[k][1]) begin
        #1;
        do_txn(k, 0);
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rsp_ready[k] = 1'b0;
      last[k] = 1;
      for (int r = 0; r < 2; r++) begin
        vld[k][r] = 1'b0; req[k][r] = '0; pend[k][r] = 1'b0; preq[k][r] = '0;
      end
    end
    repeat (2) @(negedge clk);
    check_cleared(0);
    check_cleared(1);
    rst = 1'b0;
    @(negedge clk);

    // tie from reset: requester 0 first, then 1
    present(0, 0, mk(6'b001110, 32'd33, 16'd14));
    present(0, 1, mk(6'b001110, 32'd10, 16'd8));
    #1;
    do_txn(0, 0);
    check_eq("tie_first_id",  128'(rsp_id[0]), 0);
    check_eq("tie_first_res", 128'(rsp_res[0]), 47);
    #1;
    do_txn(0, 0);
    check_eq("tie_second_id",  128'(rsp_id[0]), 1);
    check_eq("tie_second_res", 128'(rsp_res[0]), 2);

    // both again: alternation continues 0 then 1
    present(0, 0, rand_req());
    present(0, 1, rand_req());
    #1;
    do_txn(0, 0);
    check_eq("alt_id0", 128'(rsp_id[0]), 0);
    #1;
    do_txn(0, 5);
    check_eq("alt_id1", 128'(rsp_id[0]), 1);

    // requester 0 alone
    present(0, 0, mk(6'b001110, 32'd20, 16'd19));
    #1;
    do_txn(0, 0);
    check_eq("solo_res", 128'(rsp_res[0]), 7);

    // backpressure with a contender waiting
    present(0, 0, rand_req());
    present(0, 1, rand_req());
    #1;
    do_txn(0, 5);
    #1;
    do_txn(0, 0);

    for (int n = 0; n < 25; n++) random_txn(0);
    drain(0);

    for (int n = 0; n < 25; n++) random_txn(1);
    drain(1);

    // reset during EXEC aborts the op; the request is re-presented afterwards
    present(1, 0, rand_req());
    #1;
    check_eq("abort_grant", 128'(rdy[1][0]), 1);
    @(negedge clk);
    check_eq("abort_alu", 128'(alu_now(1)), 128'(preq[1][0]));
    rst = 1'b1;
    vld[1][0] = 1'b0;
    #1;
    check_cleared(1);
    @(negedge clk);
    rst = 1'b0;
    last[0] = 1;
    last[1] = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_eq("abort_norsp", 128'(rsp_valid[1]), 0);
    end
    vld[1][0] = 1'b1;
    #1;
    do_txn(1, 1);

    for (int n = 0; n < 10; n++) random_txn(1);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
